// File: rtl/wr_demux8.sv
// Single-stage write demultiplexer: a valid/ready skid register feeds a one-hot
// decoder that loads exactly one of eight bank entries per commit.
module wr_demux8_entry #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)  r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module wr_demux8 #(
  parameter int WIDTH = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  input  logic [2:0]         i_wr_sel,
  input  logic [WIDTH-1:0]   i_wr_data,
  input  logic               i_stall,
  input  logic               i_clr,
  output logic [7:0]         o_wr_en,
  output logic [8*WIDTH-1:0] o_q_flat,
  output logic [7:0]         o_written,
  output logic               o_all_written,
  output logic               o_ovw
);
  localparam int NUM_ENTRIES = 8;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           r_state;
  logic [2:0]       r_p_sel;
  logic [WIDTH-1:0] r_p_data;
  logic [7:0]       r_written;
  logic             r_ovw;

  logic             w_commit;
  logic             w_accept;
  logic [7:0]       w_wr_en;

  assign w_commit   = (r_state == FULL) && !i_stall;
  assign o_wr_ready = (r_state == EMPTY) || !i_stall;
  assign w_accept   = i_wr_valid && o_wr_ready;
  assign w_wr_en    = w_commit ? (8'd1 << r_p_sel) : 8'd0;

  // A commit frees the slot in the same cycle, so a new word can land on the commit edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= EMPTY;
      r_p_sel  <= '0;
      r_p_data <= '0;
    end else if (w_accept) begin
      r_state  <= FULL;
      r_p_sel  <= i_wr_sel;
      r_p_data <= i_wr_data;
    end else if (w_commit) begin
      r_state  <= EMPTY;
    end
  end

  // clr beats the sticky history but not the commit landing on the same edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_written <= '0;
      r_ovw     <= 1'b0;
    end else if (i_clr) begin
      r_written <= w_wr_en;
      r_ovw     <= 1'b0;
    end else if (w_commit) begin
      r_written <= r_written | w_wr_en;
      if (r_written[r_p_sel]) r_ovw <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_entry
    wr_demux8_entry #(.WIDTH(WIDTH)) u_entry (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (w_wr_en[k]),
      .i_d     (r_p_data),
      .o_q     (o_q_flat[k*WIDTH +: WIDTH])
    );
  end

  assign o_wr_en       = w_wr_en;
  assign o_written     = r_written;
  assign o_all_written = &r_written;
  assign o_ovw         = r_ovw;
endmodule
